regfile_32x64: RTL
==================

REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each register and of each data port, in bits.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers; fixed at 32 because the write-enable vector is 32 bits wide.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-low.
REQ-005 WriteEnable  input  32  one-hot (or all-zero) register write select from the upstream 5-to-32 write decoder.
REQ-006 WriteData  input  DATA_WIDTH  value to store in the selected register.
REQ-007 ReadRegister1  input  5  address for read port 1.
REQ-008 ReadRegister2  input  5  address for read port 2.
REQ-009 ReadData1  output  DATA_WIDTH  contents of register ReadRegister1.
REQ-010 ReadData2  output  DATA_WIDTH  contents of register ReadRegister2.
REQ-011 WriteConflict  output  1  registered flag: more than one bit of WriteEnable[30:0] was set on the previous edge.

Function
REQ-012 Registers 0..30 are storage; register 31 is hardwired zero: it is never written and always reads 0.
REQ-013 On a rising clk with reset high, for each i in 0..30 with WriteEnable[i]=1, register i captures WriteData.
REQ-014 WriteEnable[31] is ignored.
REQ-015 An all-zero WriteEnable leaves every register unchanged.
REQ-016 Reads are combinational: ReadData1/2 reflect the addressed register's current contents, with zero cycles of address-to-data latency.
REQ-017 Write-to-read latency without bypass: data written on edge N is visible on the read ports after edge N.
REQ-018 Both read ports are independent.
REQ-019 Both read ports may address the same register, or register 31, in the same cycle.
REQ-020 Multi-hot WriteEnable[30:0]: every selected register captures WriteData, and WriteConflict is set to 1 for exactly the following cycle.
REQ-021 WriteConflict is 0 after any edge on which WriteEnable[30:0] had at most one bit set.

Reset
REQ-022 On a rising clk with reset low, all registers 0..30 clear to 0 and WriteConflict clears to 0.
REQ-023 Writes presented during a reset edge are discarded.
REQ-024 Reset asserted mid-operation overrides any pending write on that same edge.
REQ-025 During and after reset, ReadData1/2 read 0 for every address until the first write.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN, when defined, enables write-through forwarding: if WriteEnable[ReadRegisterK]=1 and ReadRegisterK is not 31, ReadDataK shall equal WriteData combinationally in that same cycle.
REQ-027 When REGFILE_BYPASS_EN is defined, forwarding is suppressed while reset is low.
REQ-028 When REGFILE_BYPASS_EN is undefined, there is no forwarding; the read ports show the pre-edge register contents per REQ-017.

Structure
REQ-029 A shared package regfile_pkg shall hold the constants DATA_WIDTH_DEF=64, NUM_REGS=32, ADDR_W=5 and ZERO_REG=31.
REQ-030 regfile_pkg shall hold the typedef reg_data_t (logic [DATA_WIDTH-1:0]).
REQ-031 One sub-module, reg_en, shall implement a single DATA_WIDTH-bit register with enable and synchronous active-low reset; it is instantiated 31 times via generate.
REQ-032 Each read port is a 32:1 multiplexer over the register outputs and constant zero; the mux may be coded behaviourally.

Verification
REQ-033 The bench shall instantiate the existing 5-to-32 write decoder upstream to drive WriteEnable and shall cover these scenarios:
- Reset low for one edge, then read all 32 addresses on both ports -> every read returns 0 and WriteConflict=0.
- RegWrite=1, WriteRegister=5, WriteData=64'hDEADBEEF_CAFEF00D, one edge; then ReadRegister1=5 -> ReadData1=64'hDEADBEEF_CAFEF00D, and ReadData2 at address 4 reads 0.
- Write 64'hFFFF_FFFF_FFFF_FFFF targeting register 31 -> both ports at address 31 read 0 and no other register changes.
- Write register 30 with 64'h1234 and, in the next cycle, assert reset low while writing 64'h5678 to register 30 -> register 30 reads 0 after that edge.
- Drive WriteEnable=32'h0000_0003 directly with WriteData=64'hA5 -> registers 0 and 1 both read 64'hA5 and WriteConflict=1 for one cycle, then 0.
- With REGFILE_BYPASS_EN defined, write register 7 with 64'h77 while ReadRegister1=7 -> ReadData1=64'h77 before the edge.
- With REGFILE_BYPASS_EN undefined, repeat the previous scenario -> ReadData1 shows the old value before the edge and 64'h77 after it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, data type and helpers for the 31-entry + zero-register
// register file. Optional write-through forwarding in the top level is
// enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned ADDR_W         = 5;
  localparam int unsigned ZERO_REG       = 31;

  // Address of the hardwired-zero register, sized to a read address
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

  // True when more than one storage register is selected for writing
  function automatic logic is_multi_hot(input logic [ZERO_REG-1:0] sel);
    return (sel & (sel - {{(ZERO_REG-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/regfile_32x64_reg_en.sv
// Single register with load enable and synchronous active-low reset.
// One instance per storage register in regfile_32x64.
module reg_en
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Load new data when enabled, otherwise hold
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Storage flop; reset wins over any load on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/regfile_32x64.sv
// 32 x DATA_WIDTH register file: registers 0..30 are storage, register 31
// always reads zero. Two independent combinational read ports, one write
// port driven by a one-hot enable vector, and a registered flag for
// multi-hot write enables.
// Define REGFILE_BYPASS_EN to forward WriteData to a read port whose
// addressed register is being written in the same cycle.
module regfile_32x64 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [31:0]                        WriteEnable,
  input  logic [DATA_WIDTH-1:0]              WriteData,
  input  logic [regfile_pkg::ADDR_W-1:0]     ReadRegister1,
  input  logic [regfile_pkg::ADDR_W-1:0]     ReadRegister2,
  output logic [DATA_WIDTH-1:0]              ReadData1,
  output logic [DATA_WIDTH-1:0]              ReadData2,
  output logic                               WriteConflict
);

  import regfile_pkg::*;

  logic [DATA_WIDTH-1:0] reg_out [NUM_REGS];
  logic                  conflict_q;
  logic                  conflict_d;
  logic                  unused_we_zero;

  // Writes aimed at the zero register are simply dropped
  assign unused_we_zero = WriteEnable[ZERO_REG];

  // Storage registers 0..30
  for (genvar i = 0; i < int'(ZERO_REG); i++) begin : g_reg
    reg_en #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_reg (
      .clk   (clk),
      .rst_n (reset),
      .en    (WriteEnable[i]),
      .d     (WriteData),
      .q     (reg_out[i])
    );
  end

  assign reg_out[ZERO_REG] = '0;

  // Read port 1: 32:1 mux, optionally overridden by same-cycle write data
  always_comb begin
    ReadData1 = reg_out[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
    if (reset && (ReadRegister1 != ZERO_ADDR) && WriteEnable[ReadRegister1]) begin
      ReadData1 = WriteData;
    end
`endif
  end

  // Read port 2: 32:1 mux, optionally overridden by same-cycle write data
  always_comb begin
    ReadData2 = reg_out[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (reset && (ReadRegister2 != ZERO_ADDR) && WriteEnable[ReadRegister2]) begin
      ReadData2 = WriteData;
    end
`endif
  end

  // Detect more than one storage register selected this cycle
  always_comb begin
    conflict_d = is_multi_hot(WriteEnable[ZERO_REG-1:0]);
  end

  // Conflict flag holds for exactly the cycle after the offending edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign WriteConflict = conflict_q;

endmodule
